// File: rtl/bit_cell_pkg.sv
// bit_cell_pkg: shared encodings for the memory-array leaf cells.
//   RW_WRITE / RW_READ : encoding of the word-wide rw strobe.
package bit_cell_pkg;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

endpackage : bit_cell_pkg

// File: rtl/bit_cell.sv
// bit_cell: single-bit storage element of the SRAM-style array.
// Holds one bit, written through wordLine + rw, and ORs that bit onto a
// daisy-chained bitline when read, so a column resolves to one output bit.
//
// Ports:
//   clk      in   system clock, storage updates on the rising edge
//   rst      in   asynchronous active-high reset, loads RESET_VALUE
//   rw       in   access type, 1 = write, 0 = read (shared across the word)
//   wordLine in   row select, 1 = this cell is addressed
//   i        in   data bit to write
//   bitCarry in   bitline value from the previous cell (0 at column head)
//   bitOut   out  bitline value toward the next cell / sense output
module bit_cell
    import bit_cell_pkg::*;
#(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic rw,
    input  logic wordLine,
    input  logic i,
    input  logic bitCarry,
    output logic bitOut
);

    logic q_q;
    logic q_d;
    logic wr_en;
    logic rd_en;

    assign wr_en = wordLine & (rw == RW_WRITE);
    assign rd_en = wordLine & (rw == RW_READ);

    assign q_d = wr_en ? i : q_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= RESET_VALUE;
        end else begin
            q_q <= q_d;
        end
    end

    // Zero-latency read. A selected cell being written does not drive the
    // bitline, so a same-cycle read-during-write sees only bitCarry.
    assign bitOut = bitCarry | (rd_en & q_q);

endmodule : bit_cell

// File: tb/tb_bit_cell.sv
module tb_bit_cell;

    logic       clk;
    logic       clk_en;
    logic       rst;
    logic       rw;
    logic       wl;
    logic [7:0] i_w;
    logic [7:0] c_w;
    logic [7:0] bo_w;
    logic       bo1;

    int n_chk;
    int n_fail;

    // 8-cell word with RESET_VALUE = 0
    for (genvar g = 0; g < 8; g++) begin : g_word
        bit_cell #(.RESET_VALUE(1'b0)) u_cell (
            .clk      (clk),
            .rst      (rst),
            .rw       (rw),
            .wordLine (wl),
            .i        (i_w[g]),
            .bitCarry (c_w[g]),
            .bitOut   (bo_w[g])
        );
    end

    // Extra cell with RESET_VALUE = 1, sharing bit 0 data/carry
    bit_cell #(.RESET_VALUE(1'b1)) u_rv1 (
        .clk      (clk),
        .rst      (rst),
        .rw       (rw),
        .wordLine (wl),
        .i        (i_w[0]),
        .bitCarry (c_w[0]),
        .bitOut   (bo1)
    );

    initial clk = 1'b0;
    always #5 clk = clk_en ? ~clk : 1'b0;

    typedef struct {
        logic       wl;
        logic       rw;
        logic [7:0] i;
        logic [7:0] c;
        logic [7:0] exp;
        logic       exp1;
    } vec_t;

    vec_t vt [22];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic w, input logic r, input logic [7:0] d, input logic [7:0] c);
        wl  = w;
        rw  = r;
        i_w = d;
        c_w = c;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        clk_en = 1'b0;

        // Each vector is one cycle: inputs applied after negedge, output
        // checked before the following posedge, which then commits writes.
        // Start state: word q = 00, rv1 cell q = 1.
        //           wl    rw    i      c      exp    exp1
        vt[0]  = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1};
        vt[1]  = '{1'b0, 1'b1, 8'hFF, 8'h00, 8'h00, 1'b0}; // unselected write
        vt[2]  = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1}; // nothing stored
        vt[3]  = '{1'b1, 1'b1, 8'hFF, 8'h00, 8'h00, 1'b0}; // write FF, no drive
        vt[4]  = '{1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0}; // unselected
        vt[5]  = '{1'b1, 1'b0, 8'h00, 8'h00, 8'hFF, 1'b1}; // read back FF
        vt[6]  = '{1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0}; // overwrite 0
        vt[7]  = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
        vt[8]  = '{1'b1, 1'b1, 8'h55, 8'h00, 8'h00, 1'b0}; // write 55
        vt[9]  = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h55, 1'b1};
        vt[10] = '{1'b1, 1'b1, 8'h38, 8'h00, 8'h00, 1'b0}; // write 38
        vt[11] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h38, 1'b0};
        vt[12] = '{1'b1, 1'b0, 8'h00, 8'hFF, 8'hFF, 1'b1}; // carry ORs in
        vt[13] = '{1'b1, 1'b0, 8'h00, 8'hC3, 8'hFB, 1'b1};
        vt[14] = '{1'b1, 1'b1, 8'hFF, 8'h0F, 8'h0F, 1'b1}; // write passes carry
        vt[15] = '{1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0}; // pass-through
        vt[16] = '{1'b0, 1'b0, 8'h00, 8'hFF, 8'hFF, 1'b1};
        vt[17] = '{1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
        vt[18] = '{1'b0, 1'b0, 8'h00, 8'hA5, 8'hA5, 1'b1};
        vt[19] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'hFF, 1'b1};
        vt[20] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0}; // unselected write 0
        vt[21] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'hFF, 1'b1}; // still FF

        // Reset with no clock running
        drive(1'b1, 1'b0, 8'h00, 8'h00);
        rst = 1'b1;
        #3;
        chk ("reset_word", bo_w, 8'h00);
        chk1("reset_rv1",  bo1,  1'b1);
        rw = 1'b1;                    // selected write during reset: no drive
        #1;
        chk1("reset_rv1_wr", bo1, 1'b0);
        rw = 1'b0;
        #1;
        rst = 1'b0;
        #2;
        chk ("post_reset_word", bo_w, 8'h00);
        chk1("post_reset_rv1",  bo1,  1'b1);

        drive(1'b0, 1'b0, 8'h00, 8'h00);
        #1;
        clk_en = 1'b1;

        for (int k = 0; k < 22; k++) begin
            @(negedge clk);
            drive(vt[k].wl, vt[k].rw, vt[k].i, vt[k].c);
            #2;
            chk ($sformatf("vec%0d_word", k), bo_w, vt[k].exp);
            chk1($sformatf("vec%0d_rv1", k),  bo1,  vt[k].exp1);
        end

        // Async reset mid-cycle: q = FF, rv1 q = 1
        @(negedge clk);
        drive(1'b1, 1'b0, 8'h00, 8'h00);
        #1;
        rst = 1'b1;
        #1;
        chk ("async_rst_word", bo_w, 8'h00);
        chk1("async_rst_rv1",  bo1,  1'b1);

        // Write edge while reset held must be ignored
        @(negedge clk);
        drive(1'b1, 1'b1, 8'hFF, 8'h00);
        #2;
        chk ("rst_wr_word", bo_w, 8'h00);
        @(negedge clk);
        drive(1'b1, 1'b0, 8'h00, 8'h00);
        #2;
        chk ("rst_hold_word", bo_w, 8'h00);
        chk1("rst_hold_rv1",  bo1,  1'b1);

        // Release between edges, still reads reset value
        #1;
        rst = 1'b0;
        #1;
        chk ("rst_rel_word", bo_w, 8'h00);
        chk1("rst_rel_rv1",  bo1,  1'b1);

        // Next qualifying edge writes normally
        @(negedge clk);
        drive(1'b1, 1'b1, 8'hAA, 8'h00);
        #2;
        chk ("post_rst_wr", bo_w, 8'h00);
        @(negedge clk);
        drive(1'b1, 1'b0, 8'h00, 8'h00);
        #2;
        chk ("post_rst_rd_word", bo_w, 8'hAA);
        chk1("post_rst_rd_rv1",  bo1,  1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_bit_cell
